// File: rtl/alu_writeback_unit_pkg.sv
// Shared definitions for the ALU writeback stage: widths, opcodes, FSM states.
package alu_writeback_unit_pkg;

   localparam int unsigned DATA_W_DEF     = 16;
   localparam int unsigned REG_ADDR_W_DEF = 4;
   localparam int unsigned FIFO_DEPTH_DEF = 2;
   localparam int unsigned OP_W           = 3;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_MUL = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_SLL = 3'b100,
      OP_SRL = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WR_LO = 2'd1,
      ST_WR_HI = 2'd2
   } wb_state_e;

   // Codes above SRL (110, 111) carry no defined result and are dropped
   function automatic logic op_defined(input logic [2:0] op);
      return (op <= OP_SRL);
   endfunction

endpackage

// File: rtl/alu_writeback_unit_if.sv
// ALU result handshake plus register file write port of the writeback stage.
interface alu_writeback_unit_if
   import alu_writeback_unit_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [OP_W-1:0]       in_op;
   logic [REG_ADDR_W-1:0] in_rd;
   logic [2*DATA_W-1:0]   in_result;
   logic                  wb_stall;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0]     rf_wdata;

   // ALU / register file side
   modport master (
      output in_valid, in_op, in_rd, in_result, wb_stall,
      input  in_ready, rf_we, rf_waddr, rf_wdata
   );

   // Writeback unit side
   modport slave (
      input  in_valid, in_op, in_rd, in_result, wb_stall,
      output in_ready, rf_we, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/alu_writeback_unit_wb_fifo.sv
// Small synchronous FIFO with occupancy count; push ignored when full, pop ignored when empty.
module wb_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_wdata;
   end

   // Pointers wrap naturally (power-of-two depth); count tracks occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_writeback_unit.sv
// Writeback stage: buffers ALU results and drives the register file write port,
// splitting MUL results into low (rd) and high (rd+1) writes; keeps Z/V flags.
module alu_writeback_unit
   import alu_writeback_unit_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_writeback_unit_if.slave bus,
   output logic               flag_z,
   output logic               flag_v,
   output logic               busy
);

   localparam int unsigned RES_W = 2 * DATA_W;
   localparam int unsigned ENT_W = OP_W + REG_ADDR_W + RES_W;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [CNT_W-1:0]      w_count;
   logic [ENT_W-1:0]      w_head;
   logic [OP_W-1:0]       w_head_op;
   logic [REG_ADDR_W-1:0] w_head_rd;
   logic [RES_W-1:0]      w_head_res;
   logic                  w_head_mul;
   logic                  w_can_lo;

   wb_state_e             r_state;
   wb_state_e             w_state_nxt;
   logic                  r_hi_pend;
   logic                  w_lo_issue;
   logic                  w_hi_issue;
   logic                  w_drop;
   logic                  w_flag_upd;
   logic                  w_z_nxt;
   logic                  w_v_nxt;
   logic [REG_ADDR_W-1:0] w_waddr_nxt;
   logic [DATA_W-1:0]     w_wdata_nxt;

   logic                  r_we;
   logic [REG_ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0]     r_wdata;
   logic                  r_flag_z;
   logic                  r_flag_v;

   assign bus.in_ready = !w_full;
   assign w_push       = bus.in_valid && !w_full;

   wb_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata ({bus.in_op, bus.in_rd, bus.in_result}),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head_op  = w_head[ENT_W-1 -: OP_W];
   assign w_head_rd  = w_head[RES_W +: REG_ADDR_W];
   assign w_head_res = w_head[RES_W-1:0];
   assign w_head_mul = (w_head_op == OP_MUL);
   assign w_can_lo   = !w_empty && op_defined(w_head_op) && !bus.wb_stall;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state: WR_LO with a pending high half waits out stalls in place
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_can_lo) w_state_nxt = ST_WR_LO;
         end
         ST_WR_LO: begin
            if (r_hi_pend) begin
               if (!bus.wb_stall) w_state_nxt = ST_WR_HI;
            end else begin
               w_state_nxt = w_can_lo ? ST_WR_LO : ST_IDLE;
            end
         end
         ST_WR_HI: w_state_nxt = w_can_lo ? ST_WR_LO : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: an entry is popped as its final write is issued, so the
   // head already shows the next entry while that write sits on rf_*; this
   // is what lets non-MUL results stream one per cycle through a 2-deep FIFO.
   // Undefined ops are only dropped from IDLE.
   always_comb begin
      w_lo_issue = 1'b0;
      w_hi_issue = 1'b0;
      w_drop     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_lo_issue = w_can_lo;
            w_drop     = !w_empty && !op_defined(w_head_op);
         end
         ST_WR_LO: begin
            if (r_hi_pend) w_hi_issue = !bus.wb_stall;
            else           w_lo_issue = w_can_lo;
         end
         ST_WR_HI: w_lo_issue = w_can_lo;
         default: ;
      endcase
      w_pop       = (w_lo_issue && !w_head_mul) || w_hi_issue || w_drop;
      w_flag_upd  = (w_lo_issue && !w_head_mul) || w_hi_issue;
      w_z_nxt     = w_hi_issue ? (w_head_res == '0) : (w_head_res[DATA_W-1:0] == '0);
      w_v_nxt     = |w_head_res[RES_W-1:DATA_W];
      w_waddr_nxt = w_hi_issue ? (w_head_rd + REG_ADDR_W'(1)) : w_head_rd;
      w_wdata_nxt = w_hi_issue ? w_head_res[RES_W-1:DATA_W] : w_head_res[DATA_W-1:0];
   end

   // Registered write port, status flags and pending-high-half marker
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_we      <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_flag_z  <= 1'b0;
         r_flag_v  <= 1'b0;
         r_hi_pend <= 1'b0;
      end else begin
         r_we <= w_lo_issue || w_hi_issue;
         if (w_lo_issue || w_hi_issue) begin
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
         end
         if (w_flag_upd) begin
            r_flag_z <= w_z_nxt;
            r_flag_v <= w_v_nxt;
         end
         if (w_lo_issue)      r_hi_pend <= w_head_mul;
         else if (w_hi_issue) r_hi_pend <= 1'b0;
      end
   end

   assign bus.rf_we    = r_we;
   assign bus.rf_waddr = r_waddr;
   assign bus.rf_wdata = r_wdata;
   assign flag_z       = r_flag_z;
   assign flag_v       = r_flag_v;
   assign busy         = (w_count != '0) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Directed self-checking bench for alu_writeback_unit.
module tb_alu_writeback_unit;

   logic clk = 1'b0;
   logic rst_n;
   logic flag_z;
   logic flag_v;
   logic busy;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_writeback_unit_if #(.DATA_W(16), .REG_ADDR_W(4)) bus ();

   alu_writeback_unit #(
      .DATA_W     (16),
      .REG_ADDR_W (4),
      .FIFO_DEPTH (2)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .flag_z (flag_z),
      .flag_v (flag_v),
      .busy   (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic chk_wr(input string tag, input logic [3:0] a, input logic [15:0] d);
      chk({tag, "_we"},   32'(bus.rf_we),    32'd1);
      chk({tag, "_addr"}, 32'(bus.rf_waddr), 32'(a));
      chk({tag, "_data"}, 32'(bus.rf_wdata), 32'(d));
   endtask

   task automatic chk_idle_wr(input string tag);
      chk({tag, "_we"}, 32'(bus.rf_we), 32'd0);
   endtask

   task automatic chk_flags(input string tag, input logic z, input logic v);
      chk({tag, "_z"}, 32'(flag_z), 32'(z));
      chk({tag, "_v"}, 32'(flag_v), 32'(v));
   endtask

   task automatic drive(input logic [2:0] op, input logic [3:0] rd, input logic [31:0] res);
      bus.in_valid  = 1'b1;
      bus.in_op     = op;
      bus.in_rd     = rd;
      bus.in_result = res;
   endtask

   // Present one result for a single cycle; unit must be ready for it
   task automatic push1(input string tag, input logic [2:0] op, input logic [3:0] rd,
                        input logic [31:0] res);
      chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
      drive(op, rd, res);
      nxt();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 3'b000;
      bus.in_rd     = 4'd0;
      bus.in_result = 32'h0;
      bus.wb_stall  = 1'b0;
      nxt();
      nxt();

      // Reset state
      chk("rst_we",    32'(bus.rf_we),    32'd0);
      chk("rst_addr",  32'(bus.rf_waddr), 32'd0);
      chk("rst_data",  32'(bus.rf_wdata), 32'd0);
      chk_flags("rst", 1'b0, 1'b0);
      chk("rst_busy",  32'(busy),         32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      rst_n = 1'b1;

      // ADD: low half only, write two cycles after acceptance
      push1("add", 3'b000, 4'd2, 32'h0000_1234);
      chk("add_busy1", 32'(busy), 32'd1);
      chk_idle_wr("add_t1");
      nxt();
      chk_wr("add", 4'd2, 16'h1234);
      chk_flags("add", 1'b0, 1'b0);
      nxt();
      chk_idle_wr("add_t3");
      chk("add_busy3", 32'(busy), 32'd0);

      // MUL: low to r3, high to r4; flags wait for the high write
      push1("mul1", 3'b001, 4'd3, 32'h0001_FFFE);
      nxt();
      chk_wr("mul1_lo", 4'd3, 16'hFFFE);
      chk_flags("mul1_lo", 1'b0, 1'b0);
      nxt();
      chk_wr("mul1_hi", 4'd4, 16'h0001);
      chk_flags("mul1_hi", 1'b0, 1'b1);
      nxt();
      chk_idle_wr("mul1_end");
      chk("mul1_busy", 32'(busy), 32'd0);

      // MUL rd=15: high half wraps to r0, zero result
      push1("mul15", 3'b001, 4'd15, 32'h0000_0000);
      nxt();
      chk_wr("mul15_lo", 4'd15, 16'h0000);
      chk_flags("mul15_lo", 1'b0, 1'b1);
      nxt();
      chk_wr("mul15_hi", 4'd0, 16'h0000);
      chk_flags("mul15_hi", 1'b1, 1'b0);
      nxt();

      // Three MULs with in_valid held high
      drive(3'b001, 4'd1, 32'h0002_0003);
      chk("b2b_rdyA", 32'(bus.in_ready), 32'd1);
      nxt();
      drive(3'b001, 4'd5, 32'hABCD_1234);
      chk("b2b_rdyB", 32'(bus.in_ready), 32'd1);
      nxt();
      drive(3'b001, 4'd8, 32'h0000_0005);
      chk("b2b_rdy_full", 32'(bus.in_ready), 32'd0);
      chk_wr("b2b_A_lo", 4'd1, 16'h0003);
      nxt();
      chk("b2b_rdyC", 32'(bus.in_ready), 32'd1);
      chk_wr("b2b_A_hi", 4'd2, 16'h0002);
      chk_flags("b2b_A", 1'b0, 1'b1);
      nxt();
      bus.in_valid = 1'b0;
      chk_wr("b2b_B_lo", 4'd5, 16'h1234);
      nxt();
      chk_wr("b2b_B_hi", 4'd6, 16'hABCD);
      nxt();
      chk_wr("b2b_C_lo", 4'd8, 16'h0005);
      nxt();
      chk_wr("b2b_C_hi", 4'd9, 16'h0000);
      chk_flags("b2b_C", 1'b0, 1'b0);
      nxt();
      chk_idle_wr("b2b_end");
      chk("b2b_busy", 32'(busy), 32'd0);

      // Stall for 3 cycles between MUL halves
      push1("stl", 3'b001, 4'd10, 32'h5555_AAAA);
      nxt();
      chk_wr("stl_lo", 4'd10, 16'hAAAA);
      bus.wb_stall = 1'b1;
      nxt();
      chk_idle_wr("stl_s1");
      nxt();
      chk_idle_wr("stl_s2");
      nxt();
      chk_idle_wr("stl_s3");
      chk("stl_busy", 32'(busy), 32'd1);
      chk_flags("stl_hold", 1'b0, 1'b0);
      bus.wb_stall = 1'b0;
      nxt();
      chk_wr("stl_hi", 4'd11, 16'h5555);
      chk_flags("stl_hi", 1'b0, 1'b1);
      nxt();
      chk_idle_wr("stl_end");

      // Reset right after a MUL low write: high half abandoned
      push1("rmid", 3'b001, 4'd7, 32'h1234_5678);
      nxt();
      chk_wr("rmid_lo", 4'd7, 16'h5678);
      rst_n = 1'b0;
      nxt();
      chk("rmid_we",   32'(bus.rf_we),    32'd0);
      chk("rmid_addr", 32'(bus.rf_waddr), 32'd0);
      chk("rmid_data", 32'(bus.rf_wdata), 32'd0);
      chk_flags("rmid", 1'b0, 1'b0);
      chk("rmid_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      nxt();
      chk_idle_wr("rmid_after1");
      nxt();
      chk_idle_wr("rmid_after2");

      // ADD with carry out and zero low half sets both flags
      push1("carry", 3'b000, 4'd1, 32'h0001_0000);
      nxt();
      chk_wr("carry", 4'd1, 16'h0000);
      chk_flags("carry", 1'b1, 1'b1);
      nxt();

      // Undefined op 110: dropped, no write, flags unchanged
      push1("undef", 3'b110, 4'd4, 32'h0000_FFFF);
      chk("undef_busy1", 32'(busy), 32'd1);
      chk_idle_wr("undef_t1");
      nxt();
      chk_idle_wr("undef_t2");
      chk("undef_busy2", 32'(busy), 32'd0);
      chk_flags("undef", 1'b1, 1'b1);
      nxt();
      chk_idle_wr("undef_t3");

      // Unit keeps working after the drop
      push1("and", 3'b010, 4'd6, 32'h0000_0F0F);
      nxt();
      chk_wr("and", 4'd6, 16'h0F0F);
      chk_flags("and", 1'b0, 1'b0);
      nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
